// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC enable/redirect, stall and flush generation
// for load-use, memory-busy and misprediction hazards, plus branch event counters.
module hazard_ctrl #(
    parameter int unsigned LU_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_use,
    input  logic        i_mem_busy,
    input  logic        i_ex_branch,
    input  logic        i_ex_pred,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic [31:0] i_ex_pc_four,
    input  logic [31:0] i_bp_target,
    input  logic        i_cnt_clr,
    output logic        o_pc_enable,
    output logic        o_pc_sel_re,
    output logic [31:0] o_pc_br,
    output logic        o_pc_sel,
    output logic        o_stall_ifid,
    output logic        o_stall_idex,
    output logic        o_stall_exmem,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic [31:0] o_cnt_branch,
    output logic [31:0] o_cnt_mispred
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_FREEZE   = 2'd2
    } state_t;

    localparam logic [3:0] LU_INIT = 4'(LU_CYCLES - 1);

    state_t      r_state;
    state_t      r_resume;
    logic [3:0]  r_lu_cnt;
    logic [31:0] r_cnt_branch;
    logic [31:0] r_cnt_mispred;

    logic        w_mp;
    logic        w_in_lu;
    logic [31:0] w_redirect;

    assign w_mp       = i_ex_branch & (i_ex_pred ^ i_ex_taken);
    assign w_redirect = i_ex_taken ? i_ex_target : i_ex_pc_four;
    // A frozen load-use stall still counts as "in the stall" once the freeze lifts.
    assign w_in_lu    = (r_state == S_LU_STALL) |
                        ((r_state == S_FREEZE) & (r_resume == S_LU_STALL));

    assign o_cnt_branch  = r_cnt_branch;
    assign o_cnt_mispred = r_cnt_mispred;

    always_comb begin
        o_pc_enable   = 1'b0;
        o_pc_sel_re   = 1'b0;
        o_pc_br       = i_bp_target;
        o_pc_sel      = 1'b0;
        o_stall_ifid  = 1'b0;
        o_stall_idex  = 1'b0;
        o_stall_exmem = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        if (i_rst) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end else begin
            o_pc_sel = i_ex_branch & i_ex_taken & ~i_mem_busy;
            if (i_mem_busy) begin
                o_stall_ifid  = 1'b1;
                o_stall_idex  = 1'b1;
                o_stall_exmem = 1'b1;
            end else if (w_mp) begin
                o_pc_enable  = 1'b1;
                o_pc_sel_re  = 1'b1;
                o_pc_br      = w_redirect;
                o_flush_ifid = 1'b1;
                o_flush_idex = 1'b1;
            end else if (w_in_lu | i_ld_use) begin
                o_stall_ifid = 1'b1;
                o_flush_idex = 1'b1;
            end else begin
                o_pc_enable = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_resume      <= S_RUN;
            r_lu_cnt      <= 4'd0;
            r_cnt_branch  <= 32'd0;
            r_cnt_mispred <= 32'd0;
        end else begin
            if (i_cnt_clr) begin
                r_cnt_branch  <= 32'd0;
                r_cnt_mispred <= 32'd0;
            end else if (!i_mem_busy) begin
                if (i_ex_branch) r_cnt_branch  <= r_cnt_branch + 32'd1;
                if (w_mp)        r_cnt_mispred <= r_cnt_mispred + 32'd1;
            end

            if (i_mem_busy) begin
                if (r_state != S_FREEZE) r_resume <= r_state;
                r_state <= S_FREEZE;
            end else if (w_mp) begin
                r_state  <= S_RUN;
                r_lu_cnt <= 4'd0;
            end else if (w_in_lu) begin
                if (r_lu_cnt <= 4'd1) begin
                    r_state  <= S_RUN;
                    r_lu_cnt <= 4'd0;
                end else begin
                    r_state  <= S_LU_STALL;
                    r_lu_cnt <= r_lu_cnt - 4'd1;
                end
            end else if (i_ld_use && LU_CYCLES > 1) begin
                r_state  <= S_LU_STALL;
                r_lu_cnt <= LU_INIT;
            end else begin
                r_state <= S_RUN;
            end
        end
    end

endmodule
